// File: rtl/alu_b_operand_stage.sv
// ALU operand-B source select with a two-entry (output + skid) elastic buffer.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   sel            source: 0 step const, 1 rt_data, 2 ext16(imm), 3 sext({imm,2'b00}),
//                  4 zero, 5 cp0_status, 6/7 illegal (zero operand, flagged)
//   imm_signed     sign- (1) or zero- (0) extend imm for sel=2
//   rt_data        register-file RT operand
//   imm            raw instruction immediate
//   cp0_status     CP0 Status register
//   in_valid/in_ready    upstream handshake (in_ready depends only on buffer state)
//   out_valid/out_ready  downstream handshake
//   out_data       registered operand B
//   sel_err        one-cycle pulse after an illegal sel is accepted
//   err_cnt        saturating count of accepted illegal selects
module alu_b_operand_stage #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned IMM_W      = 16,
    parameter int unsigned STEP_CONST = 4,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           sel,
    input  logic                 imm_signed,
    input  logic [WIDTH-1:0]     rt_data,
    input  logic [IMM_W-1:0]     imm,
    input  logic [WIDTH-1:0]     cp0_status,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 sel_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   skid;
    logic [WIDTH-1:0]   skid_nxt;
    logic [WIDTH-1:0]   out_data_nxt;
    logic [WIDTH-1:0]   operand_c;
    logic               illegal_c;
    logic               accept;
    logic               drain;

    logic signed [IMM_W-1:0] imm_s;
    logic signed [IMM_W+1:0] imm_x4_s;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // Operand formation; signed size-casts perform the sign extension.
    always_comb begin
        imm_s     = $signed(imm);
        imm_x4_s  = $signed({imm, 2'b00});
        operand_c = '0;
        illegal_c = 1'b0;
        case (sel)
            3'd0: operand_c = WIDTH'(STEP_CONST);
            3'd1: operand_c = rt_data;
            3'd2: begin
                if (imm_signed) operand_c = WIDTH'(imm_s);
                else            operand_c = WIDTH'(imm);
            end
            3'd3: operand_c = WIDTH'(imm_x4_s);
            3'd4: operand_c = '0;
            3'd5: operand_c = cp0_status;
            default: illegal_c = 1'b1;
        endcase
    end

    // Next-state and buffer data movement.
    always_comb begin
        state_nxt    = state;
        out_data_nxt = out_data;
        skid_nxt     = skid;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt    = ST_ONE;
                    out_data_nxt = operand_c;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    out_data_nxt = operand_c;
                end else if (accept) begin
                    state_nxt = ST_TWO;
                    skid_nxt  = operand_c;
                end else if (drain) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    state_nxt    = ST_ONE;
                    out_data_nxt = skid;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    // Registered outputs, buffer entries and error tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            skid      <= '0;
            sel_err   <= 1'b0;
            err_cnt   <= '0;
        end else begin
            in_ready  <= (state_nxt != ST_TWO);
            out_valid <= (state_nxt != ST_EMPTY);
            out_data  <= out_data_nxt;
            skid      <= skid_nxt;
            sel_err   <= accept && illegal_c;
            if (accept && illegal_c && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Scoreboard bench for alu_b_operand_stage: the driver records the hand-computed
// operand of every accepted transfer, the monitor compares on every drain.
module tb_alu_b_operand_stage;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned IMM_W     = 16;
    localparam int unsigned ERR_CNT_W = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [2:0]           sel;
    logic                 imm_signed;
    logic [WIDTH-1:0]     rt_data;
    logic [IMM_W-1:0]     imm;
    logic [WIDTH-1:0]     cp0_status;
    logic                 in_valid;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 sel_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    alu_b_operand_stage #(
        .WIDTH(WIDTH), .IMM_W(IMM_W), .STEP_CONST(4), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .sel(sel), .imm_signed(imm_signed),
        .rt_data(rt_data), .imm(imm), .cp0_status(cp0_status),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sel_err(sel_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [WIDTH-1:0]     exp_q[$];
    logic [WIDTH-1:0]     drv_exp;
    logic                 drv_ill;
    logic                 exp_err;
    logic [ERR_CNT_W-1:0] exp_cnt;
    int                   checks = 0;
    int                   passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got === want) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the posedge+1 phase; holds the request until accepted.
    task automatic send(input logic [2:0] s, input logic sg, input logic [15:0] im,
                        input logic [31:0] rt, input logic [31:0] cp, input logic [31:0] e);
        logic got_ready;
        sel = s; imm_signed = sg; imm = im; rt_data = rt; cp0_status = cp;
        drv_exp = e; drv_ill = (s >= 3'd6); in_valid = 1'b1;
        got_ready = 1'b0;
        for (int k = 0; k < 100 && !got_ready; k++) begin
            @(negedge clk);
            got_ready = in_ready;
        end
        if (!got_ready) begin
            checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 expected 1 at %0t", $time);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drv_ill  = 1'b0;
    endtask

    // Accept tracker: pushes expected operand and error expectations.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
            exp_cnt = '0;
        end else begin
            exp_err = 1'b0;
            if (in_valid && in_ready) begin
                exp_q.push_back(drv_exp);
                if (drv_ill) begin
                    exp_err = 1'b1;
                    if (exp_cnt != '1) exp_cnt++;
                end
            end
        end
    end

    // Monitor: compare error outputs every cycle, operand on every drain.
    always @(negedge clk) begin
        if (!rst) begin
            check("sel_err", 64'(sel_err), 64'(exp_err));
            check("err_cnt", 64'(err_cnt), 64'(exp_cnt));
            if (out_valid && exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_out: out_valid=1 data 0x%0h expected no operand at %0t",
                         out_data, $time);
            end else if (out_valid && out_ready) begin
                check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish expected finish by 100000");
        $fatal(1);
    end

    initial begin
        sel = 3'd0; imm_signed = 1'b0; rt_data = '0; imm = '0; cp0_status = '0;
        in_valid = 1'b0; out_ready = 1'b0; drv_exp = '0; drv_ill = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_sel_err",   64'(sel_err),   64'd0);
        check("rst_err_cnt",   64'(err_cnt),   64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_pre_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("in_ready_post_edge", 64'(in_ready), 64'd1);
        check("idle_out_valid", 64'(out_valid), 64'd0);

        // Step constant, one-cycle latency
        tick();
        out_ready = 1'b1;
        send(3'd0, 1'b0, 16'h0000, 32'h0, 32'h0, 32'h0000_0004);
        @(negedge clk);
        check("step_out_valid", 64'(out_valid), 64'd1);
        check("step_out_data",  64'(out_data),  64'h4);
        tick();

        // Source patterns back to back
        send(3'd2, 1'b1, 16'h8000, 32'h0, 32'h0, 32'hFFFF_8000);
        send(3'd2, 1'b0, 16'h8000, 32'h0, 32'h0, 32'h0000_8000);
        send(3'd3, 1'b0, 16'hFFFF, 32'h0, 32'h0, 32'hFFFF_FFFC);
        send(3'd3, 1'b1, 16'h7FFF, 32'h0, 32'h0, 32'h0001_FFFC);
        send(3'd3, 1'b0, 16'h0001, 32'h0, 32'h0, 32'h0000_0004);
        send(3'd2, 1'b1, 16'h1234, 32'h0, 32'h0, 32'h0000_1234);
        send(3'd1, 1'b0, 16'hFFFF, 32'hDEAD_BEEF, 32'h0, 32'hDEAD_BEEF);
        send(3'd4, 1'b1, 16'hFFFF, 32'h1, 32'h1, 32'h0000_0000);
        send(3'd6, 1'b1, 16'hFFFF, 32'h1, 32'h1, 32'h0000_0000);
        repeat (3) tick();

        // Fill both entries, stall, then drain in order
        out_ready = 1'b0;
        send(3'd1, 1'b0, 16'h0, 32'h11, 32'h0, 32'h11);
        send(3'd1, 1'b0, 16'h0, 32'h22, 32'h0, 32'h22);
        sel = 3'd7; in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("two_in_ready",  64'(in_ready),  64'd0);
            check("two_out_valid", 64'(out_valid), 64'd1);
            check("two_hold_data", 64'(out_data),  64'h11);
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain_first",  64'(out_data), 64'h11);
        @(negedge clk);
        check("drain_second", 64'(out_data), 64'h22);
        @(negedge clk);
        check("drain_empty",  64'(out_valid), 64'd0);
        tick();

        // Simultaneous accept and drain in ONE
        out_ready = 1'b0;
        send(3'd1, 1'b0, 16'h0, 32'h5, 32'h0, 32'h5);
        out_ready = 1'b1;
        send(3'd5, 1'b0, 16'h0, 32'h0, 32'h0000_FF01, 32'h0000_FF01);
        @(negedge clk);
        check("one_out_valid", 64'(out_valid), 64'd1);
        check("one_in_ready",  64'(in_ready),  64'd1);
        check("one_out_data",  64'(out_data),  64'h0000_FF01);
        tick();

        // Illegal sel without in_valid has no effect
        sel = 3'd7; in_valid = 1'b0;
        repeat (3) tick();

        // Illegal sel flood: counter saturates
        for (int n = 0; n < 260; n++) send(3'd7, 1'b0, 16'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) tick();
        check("err_cnt_sat", 64'(err_cnt), 64'hFF);

        // Asynchronous reset while full
        out_ready = 1'b0;
        send(3'd1, 1'b0, 16'h0, 32'hAA, 32'h0, 32'hAA);
        send(3'd1, 1'b0, 16'h0, 32'hBB, 32'h0, 32'hBB);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_in_ready",  64'(in_ready),  64'd0);
        check("arst_out_data",  64'(out_data),  64'd0);
        check("arst_err_cnt",   64'(err_cnt),   64'd0);
        check("arst_sel_err",   64'(sel_err),   64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_stale", 64'(out_valid), 64'd0);
        end
        tick();
        send(3'd1, 1'b0, 16'h0, 32'h33, 32'h0, 32'h33);
        @(negedge clk);
        check("post_rst_data", 64'(out_data), 64'h33);
        repeat (2) tick();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
